// File: rtl/kr580_io_uart.sv
// kr580 port-bus 8N1 UART: data register at BASE, status/control at BASE+1, TX/RX FIFOs, level interrupt.
// Latency: pin_pi is combinational; start bit leaves 1 clock after a push to an idle TX path; RX byte lands at mid-stop.
// Backpressure: none on the bus; TX writes to a full FIFO are dropped, RX bytes into a full FIFO are dropped with rx_ovr.

module kr580_io_uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_dat,
    input  logic       i_pop,
    output logic [7:0] o_dat,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_pop_ok;
    logic        w_push_ok;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    // A pop in the same clock frees the slot, so a push into a full FIFO still lands.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_dat     = r_mem[r_rptr[AW-1:0]];

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_dat;
    end
endmodule

module kr580_io_uart #(
    parameter logic [7:0] BASE    = 8'h10,
    parameter int         CLK_DIV = 217,
    parameter int         DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] pin_pa,
    input  logic [7:0] pin_po,
    input  logic       pin_pw,
    output logic [7:0] pin_pi,
    output logic       intr,
    input  logic       uart_rx,
    output logic       uart_tx
);
    localparam int            CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [7:0]    ADDR_DAT  = BASE;
    localparam logic [7:0]    ADDR_CTL  = BASE + 8'd1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_t;

    // Bus decode
    logic w_wr_dat, w_wr_ctl, w_rx_pop, w_err_clr;
    assign w_wr_dat  = pin_pw && (pin_pa == ADDR_DAT);
    assign w_wr_ctl  = pin_pw && (pin_pa == ADDR_CTL);
    assign w_rx_pop  = w_wr_ctl && pin_po[0];
    assign w_err_clr = w_wr_ctl && pin_po[1];

    // FIFOs
    logic [7:0] w_tx_head, w_rx_head;
    logic       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic       w_tx_pop, w_rx_push;
    logic [7:0] r_rx_shift;

    kr580_io_uart_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_wr_dat),
        .i_dat   (pin_po),
        .i_pop   (w_tx_pop),
        .o_dat   (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    kr580_io_uart_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_rx_push),
        .i_dat   (r_rx_shift),
        .i_pop   (w_rx_pop),
        .o_dat   (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    // ---------------- TX ----------------
    uart_st_t      r_tx_st, w_tx_st_nxt;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]    r_tx_bit, w_tx_bit_nxt;
    logic [7:0]    r_tx_shift, w_tx_shift_nxt;
    logic          r_tx_line, w_tx_line_nxt;
    logic          w_tx_tick, w_tx_idle;

    assign w_tx_tick = (r_tx_cnt == DIV_LAST);
    assign w_tx_idle = w_tx_empty && (r_tx_st == S_IDLE);
    assign uart_tx   = r_tx_line;

    // TX state register; the line level is registered so the serial pin never glitches.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_st    <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_st    <= w_tx_st_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_line  <= w_tx_line_nxt;
        end
    end

    // TX next state: STOP chains straight into START when another byte is waiting.
    always_comb begin
        w_tx_st_nxt    = r_tx_st;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_pop       = 1'b0;
        case (r_tx_st)
            S_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_shift_nxt = w_tx_head;
                    w_tx_cnt_nxt   = '0;
                    w_tx_st_nxt    = S_START;
                end
            end
            S_START: begin
                if (w_tx_tick) begin
                    w_tx_cnt_nxt = '0;
                    w_tx_bit_nxt = '0;
                    w_tx_st_nxt  = S_DATA;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_tx_tick) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_nxt   = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) w_tx_st_nxt = S_STOP;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_tx_tick) begin
                    w_tx_cnt_nxt = '0;
                    if (!w_tx_empty) begin
                        w_tx_pop       = 1'b1;
                        w_tx_shift_nxt = w_tx_head;
                        w_tx_st_nxt    = S_START;
                    end else begin
                        w_tx_st_nxt = S_IDLE;
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                end
            end
        endcase
        case (w_tx_st_nxt)
            S_START: w_tx_line_nxt = 1'b0;
            S_DATA:  w_tx_line_nxt = w_tx_shift_nxt[0];
            default: w_tx_line_nxt = 1'b1;
        endcase
    end

    // ---------------- RX ----------------
    logic          r_rx_s1, r_rx_s2, r_rx_prev;
    uart_st_t      r_rx_st, w_rx_st_nxt;
    logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]    r_rx_bit, w_rx_bit_nxt;
    logic [7:0]    w_rx_shift_nxt;
    logic          w_rx_tick, w_fe_set, w_ovr_set;

    assign w_rx_tick = (r_rx_cnt == DIV_LAST);
    // Full FIFO with no CPU pop this clock means the incoming byte is lost.
    assign w_ovr_set = w_rx_push && w_rx_full && !w_rx_pop;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idle is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= uart_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // RX state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_st    <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_st    <= w_rx_st_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
        end
    end

    // RX next state: re-centre at mid-start, then sample once per bit period.
    always_comb begin
        w_rx_st_nxt    = r_rx_st;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_push      = 1'b0;
        w_fe_set       = 1'b0;
        case (r_rx_st)
            S_IDLE: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_cnt_nxt = '0;
                    w_rx_st_nxt  = S_START;
                end
            end
            S_START: begin
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_nxt = '0;
                    w_rx_bit_nxt = '0;
                    w_rx_st_nxt  = r_rx_s2 ? S_IDLE : S_DATA;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_rx_tick) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
                    w_rx_bit_nxt   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_st_nxt = S_STOP;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_rx_tick) begin
                    w_rx_cnt_nxt = '0;
                    w_rx_st_nxt  = S_IDLE;
                    if (r_rx_s2) w_rx_push = 1'b1;
                    else         w_fe_set  = 1'b1;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
        endcase
    end

    // ---------------- Control, flags, interrupt ----------------
    logic r_rxie, r_txie, r_rx_ovr, r_frame_err, r_intr;
    logic [7:0] w_status;

    assign w_status = {r_txie, r_rxie, r_frame_err, r_rx_ovr,
                       w_tx_idle, w_tx_full, w_rx_full, !w_rx_empty};
    assign intr     = r_intr;

    // Enables follow every control write; error set beats a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rxie      <= 1'b0;
            r_txie      <= 1'b0;
            r_rx_ovr    <= 1'b0;
            r_frame_err <= 1'b0;
            r_intr      <= 1'b0;
        end else begin
            if (w_wr_ctl) begin
                r_rxie <= pin_po[2];
                r_txie <= pin_po[3];
            end
            if (w_ovr_set)      r_rx_ovr <= 1'b1;
            else if (w_err_clr) r_rx_ovr <= 1'b0;
            if (w_fe_set)       r_frame_err <= 1'b1;
            else if (w_err_clr) r_frame_err <= 1'b0;
            r_intr <= (r_rxie && !w_rx_empty) || (r_txie && w_tx_idle);
        end
    end

    // Read mux: data port peeks the RX head without consuming it.
    always_comb begin
        pin_pi = 8'h00;
        if (pin_pa == ADDR_DAT)      pin_pi = w_rx_empty ? 8'h00 : w_rx_head;
        else if (pin_pa == ADDR_CTL) pin_pi = w_status;
    end
endmodule

// File: tb/tb_kr580_io_uart.sv
// Bench for kr580_io_uart: bus reads/writes, bit-level TX check, loopback and driven-RX scoreboards.
// Latency: samples 1 ns after each rising edge; serial frames built in whole bit periods.
// Backpressure: exercises TX FIFO drop and RX overrun.

module tb_kr580_io_uart;
    localparam logic [7:0] BASE  = 8'h10;
    localparam int         D     = 16;
    localparam int         DEPTH = 4;
    localparam logic [7:0] A_DAT = BASE;
    localparam logic [7:0] A_CTL = BASE + 8'd1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pin_pa = 8'h00;
    logic [7:0] pin_po = 8'h00;
    logic       pin_pw = 1'b0;
    logic [7:0] pin_pi;
    logic       intr;
    logic       uart_tx;
    logic       uart_rx;
    logic       tb_rx = 1'b1;
    logic       lb = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    assign uart_rx = lb ? uart_tx : tb_rx;

    kr580_io_uart #(.BASE(BASE), .CLK_DIV(D), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .pin_pa  (pin_pa),
        .pin_po  (pin_po),
        .pin_pw  (pin_pw),
        .pin_pi  (pin_pi),
        .intr    (intr),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        pin_pa = a;
        pin_po = d;
        pin_pw = 1'b1;
        tick(1);
        pin_pw = 1'b0;
        pin_pa = 8'h00;
        pin_po = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        pin_pa = a;
        #1;
        d = pin_pi;
    endtask

    task automatic send_serial(input logic [7:0] b, input logic stop);
        tb_rx = 1'b0;
        tick(D);
        for (int i = 0; i < 8; i++) begin
            tb_rx = b[i];
            tick(D);
        end
        tb_rx = stop;
        tick(D);
        tb_rx = 1'b1;
    endtask

    task automatic wait_rx_ne(output bit ok);
        logic [7:0] s;
        ok = 1'b0;
        for (int w = 0; w < 14 * D; w++) begin
            rd(A_CTL, s);
            if (s[0]) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    // Waits for a start bit on uart_tx and samples the frame at mid-bit.
    task automatic cap_frame(output logic [7:0] d, output int t0, output bit ok);
        ok = 1'b0;
        t0 = 0;
        d  = 8'h00;
        for (int w = 0; w < 30 * D; w++) begin
            if (uart_tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (ok) begin
            t0 = cyc;
            tick(D / 2);
            if (uart_tx !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick(D);
                d[i] = uart_tx;
            end
            tick(D);
            if (uart_tx !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL reset_intr: got %b want 0", intr); end
        rd(A_CTL, v);
        n_cmp++; if (v !== 8'h08) begin n_bad++; $display("FAIL reset_status: got %h want 08", v); end
        rd(A_DAT, v);
        n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", v); end
        rd(8'h42, v);
        n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL unmapped_read: got %h want 00", v); end
    endtask

    task automatic test_tx_frame();
        logic [9:0] pat;
        logic [7:0] v;
        pat = {1'b1, 8'h55, 1'b0};
        bus_wr(A_DAT, 8'h55);
        tick(1 + D / 2);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (uart_tx !== pat[i]) begin
                n_bad++;
                $display("FAIL tx_bit%0d: got %b want %b", i, uart_tx, pat[i]);
            end
            if (i < 9) tick(D);
        end
        tick(D / 2 - 1);
        rd(A_CTL, v);
        n_cmp++; if (v[3] !== 1'b0) begin n_bad++; $display("FAIL tx_idle_early: got %b want 0", v[3]); end
        tick(1);
        rd(A_CTL, v);
        n_cmp++; if (v[3] !== 1'b1) begin n_bad++; $display("FAIL tx_idle_late: got %b want 1", v[3]); end
    endtask

    task automatic test_loopback();
        logic [7:0] v;
        bit ok;
        lb = 1'b1;
        exp_rx.push_back(8'hA3);
        bus_wr(A_DAT, 8'hA3);
        wait_rx_ne(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL lb_rx_ne: got timeout want rx_ne=1"); end
        rd(A_DAT, v);
        n_cmp++; if (v !== exp_rx.pop_front()) begin n_bad++; $display("FAIL lb_data: got %h want a3", v); end
        bus_wr(A_CTL, 8'h01);
        rd(A_CTL, v);
        n_cmp++; if (v[0] !== 1'b0) begin n_bad++; $display("FAIL lb_pop_ne: got %b want 0", v[0]); end
        rd(A_DAT, v);
        n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL lb_pop_data: got %h want 00", v); end
        tick(D);
        lb = 1'b0;
        tick(2);
    endtask

    task automatic test_rx_overflow();
        logic [7:0] v, b;
        for (int i = 0; i <= DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < DEPTH) exp_rx.push_back(b);
            send_serial(b, 1'b1);
        end
        tick(4);
        rd(A_CTL, v);
        n_cmp++; if (v !== 8'h1B) begin n_bad++; $display("FAIL ovr_status: got %h want 1b", v); end
        for (int i = 0; i < DEPTH; i++) begin
            rd(A_DAT, v);
            b = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'hxx;
            n_cmp++; if (v !== b) begin n_bad++; $display("FAIL ovr_read%0d: got %h want %h", i, v, b); end
            bus_wr(A_CTL, 8'h01);
        end
        rd(A_CTL, v);
        n_cmp++; if (v !== 8'h18) begin n_bad++; $display("FAIL ovr_drained: got %h want 18", v); end
        bus_wr(A_CTL, 8'h02);
        rd(A_CTL, v);
        n_cmp++; if (v !== 8'h08) begin n_bad++; $display("FAIL ovr_clear: got %h want 08", v); end
    endtask

    task automatic test_frame_err_glitch();
        logic [7:0] v;
        int g;
        exp_rx.push_back(8'h5A);
        send_serial(8'h5A, 1'b1);
        send_serial(8'hC3, 1'b0);
        tick(4);
        rd(A_CTL, v);
        n_cmp++; if (v !== 8'h29) begin n_bad++; $display("FAIL ferr_status: got %h want 29", v); end
        rd(A_DAT, v);
        n_cmp++; if (v !== exp_rx.pop_front()) begin n_bad++; $display("FAIL ferr_head: got %h want 5a", v); end
        bus_wr(A_CTL, 8'h03);
        rd(A_CTL, v);
        n_cmp++; if (v !== 8'h08) begin n_bad++; $display("FAIL ferr_clear: got %h want 08", v); end
        g = (3 * D) / 10;
        tb_rx = 1'b0;
        tick(g);
        tb_rx = 1'b1;
        tick(12 * D);
        rd(A_CTL, v);
        n_cmp++; if (v !== 8'h08) begin n_bad++; $display("FAIL glitch_status: got %h want 08", v); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v, d, e;
        int t0, tprev, lows;
        bit ok;
        bus_wr(A_CTL, 8'h0C);
        n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL intr_lag: got %b want 0", intr); end
        tick(1);
        n_cmp++; if (intr !== 1'b1) begin n_bad++; $display("FAIL intr_txidle: got %b want 1", intr); end
        tprev = 0;
        fork
            begin
                exp_tx.push_back(8'h81);
                bus_wr(A_DAT, 8'h81);
                tick(1);
                for (int i = 0; i <= DEPTH; i++) begin
                    v = 8'hC0 + 8'(i * 5);
                    if (i < DEPTH) exp_tx.push_back(v);
                    bus_wr(A_DAT, v);
                end
                n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL intr_busy: got %b want 0", intr); end
                rd(A_CTL, v);
                n_cmp++; if (v !== 8'hC4) begin n_bad++; $display("FAIL txfull_status: got %h want c4", v); end
            end
            begin
                for (int f = 0; f <= DEPTH; f++) begin
                    cap_frame(d, t0, ok);
                    e = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'hxx;
                    n_cmp++;
                    if (!ok || d !== e) begin
                        n_bad++;
                        $display("FAIL tx_frame%0d: got %h ok=%0d want %h", f, d, ok, e);
                    end
                    if (f > 0) begin
                        n_cmp++;
                        if (t0 - tprev != 10 * D) begin
                            n_bad++;
                            $display("FAIL tx_gap%0d: got %0d want %0d", f, t0 - tprev, 10 * D);
                        end
                    end
                    tprev = t0;
                end
            end
        join
        lows = 0;
        for (int i = 0; i < 12 * D; i++) begin
            if (uart_tx !== 1'b1) lows++;
            tick(1);
        end
        n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL tx_extra_frame: got %0d low clocks want 0", lows); end
        n_cmp++; if (intr !== 1'b1) begin n_bad++; $display("FAIL intr_drained: got %b want 1", intr); end
        rd(A_CTL, v);
        n_cmp++; if (v !== 8'hC8) begin n_bad++; $display("FAIL drained_status: got %h want c8", v); end
        bus_wr(A_CTL, 8'h00);
        tick(2);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] v;
        bit ok;
        send_serial(8'h66, 1'b1);
        tick(4);
        bus_wr(A_CTL, 8'h04);
        tick(1);
        n_cmp++; if (intr !== 1'b1) begin n_bad++; $display("FAIL intr_rx: got %b want 1", intr); end
        lb = 1'b1;
        bus_wr(A_DAT, 8'h99);
        tick(4 * D);
        reset = 1'b1;
        tick(1);
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL midrst_tx: got %b want 1", uart_tx); end
        n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL midrst_intr: got %b want 0", intr); end
        reset = 1'b0;
        rd(A_CTL, v);
        n_cmp++; if (v !== 8'h08) begin n_bad++; $display("FAIL midrst_status: got %h want 08", v); end
        rd(A_DAT, v);
        n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL midrst_data: got %h want 00", v); end
        tick(2 * D);
        exp_rx.push_back(8'h3C);
        bus_wr(A_DAT, 8'h3C);
        wait_rx_ne(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL postrst_rx_ne: got timeout want rx_ne=1"); end
        rd(A_DAT, v);
        n_cmp++; if (v !== exp_rx.pop_front()) begin n_bad++; $display("FAIL postrst_data: got %h want 3c", v); end
        tick(D);
        lb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback();
        test_rx_overflow();
        test_frame_err_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
